// File: rtl/sap_sequencer.sv
// Purpose: T-state controller for the 8-bit bus computer: fetch T1-T3, opcode-dependent execute T4-T7.
// Latency: outputs decode combinationally from the current T-state and opcode; the state advances one step per enabled edge.
// Backpressure: in single-step mode the state holds between STEP pulses, and the WE/PC_EN strobes stay low while it holds.
module sap_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int STEP_EN = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       STEP_MODE,
  input  logic       STEP,
  input  logic [7:0] IR_IN,
  input  logic       ZERO,
  output logic [3:0] BUS_SRC,
  output logic [3:0] BUS_DST,
  output logic       OE,
  output logic       WE,
  output logic       PC_EN,
  output logic [2:0] OP,
  output logic       HLT,
  output logic [2:0] T_STATE
);

  // T1..T7 occupy codes 1..7, so the low three bits give T_STATE directly.
  // IDLE (0) and HALT (8) both report 0.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [3:0] M_PC   = 4'd0;
  localparam logic [3:0] M_ACC  = 4'd1;
  localparam logic [3:0] M_BREG = 4'd2;
  localparam logic [3:0] M_ALU  = 4'd3;
  localparam logic [3:0] M_MAR  = 4'd4;
  localparam logic [3:0] M_MEM  = 4'd5;
  localparam logic [3:0] M_IR   = 4'd6;
  localparam logic [3:0] M_OR   = 4'd8;

  localparam logic [3:0] OPC_LDA = 4'h0;
  localparam logic [3:0] OPC_ADD = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_LDB = 4'h3;
  localparam logic [3:0] OPC_INC = 4'h4;
  localparam logic [3:0] OPC_DEC = 4'h5;
  localparam logic [3:0] OPC_JMP = 4'h6;
  localparam logic [3:0] OPC_JZ  = 4'h7;
  localparam logic [3:0] OPC_OUT = 4'hE;
  localparam logic [3:0] OPC_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_DEC = 3'b010;
  localparam logic [2:0] ALU_INC = 3'b011;

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic       adv;
  logic       we_raw, pc_raw;
  logic [2:0] op_dec;

  // The operand field is consumed by the datapath over the bus, not by the sequencer.
  logic operand_unused;
  assign operand_unused = ^IR_IN[ADDR_W-1:0];

  assign opcode = IR_IN[7:4];
  assign adv    = ~((STEP_EN != 0) & STEP_MODE) | STEP;

  // ALU op for the current instruction; non-ALU instructions leave it at ADD (000).
  always_comb begin
    op_dec = ALU_ADD;
    case (opcode)
      OPC_SUB: op_dec = ALU_SUB;
      OPC_INC: op_dec = ALU_INC;
      OPC_DEC: op_dec = ALU_DEC;
      default: op_dec = ALU_ADD;
    endcase
  end

  // Next-state and Moore output decode; the state is frozen whenever ADV is low.
  always_comb begin
    state_d = state_q;
    BUS_SRC = M_PC;
    BUS_DST = M_PC;
    OE      = 1'b0;
    we_raw  = 1'b0;
    pc_raw  = 1'b0;
    OP      = ALU_ADD;
    HLT     = 1'b0;
    case (state_q)
      S_IDLE: if (RUN) state_d = S_T1;
      S_T1: begin
        BUS_SRC = M_PC;  BUS_DST = M_MAR; OE = 1'b1; we_raw = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        pc_raw  = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        BUS_SRC = M_MEM; BUS_DST = M_IR; OE = 1'b1; we_raw = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        OP      = op_dec;
        state_d = S_T1;
        case (opcode)
          OPC_LDA, OPC_LDB, OPC_ADD, OPC_SUB: begin
            BUS_SRC = M_IR; BUS_DST = M_MAR; OE = 1'b1; we_raw = 1'b1;
            state_d = S_T5;
          end
          OPC_INC, OPC_DEC: state_d = S_T5;
          OPC_JMP: begin
            BUS_SRC = M_IR; BUS_DST = M_PC; OE = 1'b1; we_raw = 1'b1;
          end
          OPC_JZ: if (ZERO) begin
            BUS_SRC = M_IR; BUS_DST = M_PC; OE = 1'b1; we_raw = 1'b1;
          end
          OPC_OUT: begin
            BUS_SRC = M_ACC; BUS_DST = M_OR; OE = 1'b1; we_raw = 1'b1;
          end
          OPC_HLT: state_d = S_HALT;
          default: state_d = S_T1;
        endcase
      end
      S_T5: begin
        OP      = op_dec;
        state_d = S_T1;
        case (opcode)
          OPC_LDA: begin
            BUS_SRC = M_MEM; BUS_DST = M_ACC; OE = 1'b1; we_raw = 1'b1;
          end
          OPC_LDB: begin
            BUS_SRC = M_MEM; BUS_DST = M_BREG; OE = 1'b1; we_raw = 1'b1;
          end
          OPC_ADD, OPC_SUB: begin
            BUS_SRC = M_MEM; BUS_DST = M_BREG; OE = 1'b1; we_raw = 1'b1;
            state_d = S_T6;
          end
          OPC_INC, OPC_DEC: begin
            BUS_SRC = M_ALU; BUS_DST = M_ACC; OE = 1'b1; we_raw = 1'b1;
          end
          default: state_d = S_T1;
        endcase
      end
      // Idle cycle that gives the registered ALU a cycle to settle on the new BREG value.
      S_T6: begin
        OP      = op_dec;
        state_d = S_T7;
      end
      S_T7: begin
        OP      = op_dec;
        BUS_SRC = M_ALU; BUS_DST = M_ACC; OE = 1'b1; we_raw = 1'b1;
        state_d = S_T1;
      end
      S_HALT: HLT = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (!adv) state_d = state_q;
  end

  assign WE      = we_raw & adv;
  assign PC_EN   = pc_raw & adv;
  assign T_STATE = state_q[2:0];

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_sap_sequencer.sv
// Purpose: directed tests for sap_sequencer covering fetch, every execute shape, single-step and halt.
// Latency: inputs are driven at the falling edge, and outputs are sampled 1 ns after it.
// Backpressure: STEP pulses are driven for one cycle at a time in single-step mode.
module tb_sap_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RUN = 1'b0;
  logic       STEP_MODE = 1'b0;
  logic       STEP = 1'b0;
  logic [7:0] IR_IN = 8'h00;
  logic       ZERO = 1'b0;
  logic [3:0] BUS_SRC, BUS_DST;
  logic       OE, WE, PC_EN, HLT;
  logic [2:0] OP, T_STATE;

  int passed = 0;
  int total  = 0;

  sap_sequencer #(.ADDR_W(4), .STEP_EN(1)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP_MODE(STEP_MODE), .STEP(STEP),
    .IR_IN(IR_IN), .ZERO(ZERO), .BUS_SRC(BUS_SRC), .BUS_DST(BUS_DST),
    .OE(OE), .WE(WE), .PC_EN(PC_EN), .OP(OP), .HLT(HLT), .T_STATE(T_STATE)
  );

  always #5 CLK = ~CLK;

  // Vector layout: {T_STATE, BUS_SRC, BUS_DST, OE, WE, PC_EN, OP, HLT}.
  function automatic logic [17:0] v(input logic [2:0] t, input logic [3:0] s, input logic [3:0] d,
                                    input logic oe, input logic we, input logic pc,
                                    input logic [2:0] op, input logic h);
    return {t, s, d, oe, we, pc, op, h};
  endfunction

  function automatic logic [17:0] obs();
    return {T_STATE, BUS_SRC, BUS_DST, OE, WE, PC_EN, OP, HLT};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    #1 RESET = 1'b1;
    #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL reset_initial got %h want %h", obs(), 18'h0);
    else passed++;
    @(negedge CLK); #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL reset_held got %h want %h", obs(), 18'h0);
    else passed++;
    RESET = 1'b0;
    // Run ADD up to T5, then hit reset asynchronously mid-instruction.
    IR_IN = 8'h17; RUN = 1'b1;
    do_reset();
    repeat (5) @(negedge CLK);
    #1;
    e = v(3'd5, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    total++;
    if (obs() !== e) $display("FAIL reset_pre_t5 got %h want %h", obs(), e);
    else passed++;
    #1 RESET = 1'b1;
    #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL reset_async got %h want %h", obs(), 18'h0);
    else passed++;
    @(posedge CLK); #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL reset_over_edge got %h want %h", obs(), 18'h0);
    else passed++;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK); #1;
    e = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    total++;
    if (obs() !== e) $display("FAIL reset_release_t1 got %h want %h", obs(), e);
    else passed++;
  endtask

  task automatic test_lda();
    logic [17:0] ev [6];
    ev[0] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[1] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    ev[2] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[3] = v(3'd4, 4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[4] = v(3'd5, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[5] = ev[0];
    IR_IN = 8'h05; RUN = 1'b1; ZERO = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); #1;
      total++;
      if (obs() !== ev[i]) $display("FAIL lda step%0d got %h want %h", i, obs(), ev[i]);
      else passed++;
    end
  endtask

  task automatic test_add_sub();
    logic [17:0] ev [8];
    logic [2:0]  op;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 3'b000 : 3'b001;
      ev[0] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      ev[1] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      ev[2] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      ev[3] = v(3'd4, 4'd6, 4'd4, 1'b1, 1'b1, 1'b0, op, 1'b0);
      ev[4] = v(3'd5, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, op, 1'b0);
      ev[5] = v(3'd6, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, op, 1'b0);
      ev[6] = v(3'd7, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, op, 1'b0);
      ev[7] = ev[0];
      IR_IN = (k == 0) ? 8'h17 : 8'h29;
      RUN = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK); #1;
        total++;
        if (obs() !== ev[i]) $display("FAIL add_sub k%0d step%0d got %h want %h", k, i, obs(), ev[i]);
        else passed++;
        // Dropping RUN mid-instruction must not stop the sequencer.
        if (i == 0) RUN = 1'b0;
      end
    end
  endtask

  task automatic test_inc_dec_ldb();
    logic [17:0] ev [6];
    logic [7:0]  irs [3];
    irs[0] = 8'h40; irs[1] = 8'h51; irs[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      ev[0] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      ev[1] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      ev[2] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      if (k == 0) begin
        ev[3] = v(3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
        ev[4] = v(3'd5, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0);
      end else if (k == 1) begin
        ev[3] = v(3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
        ev[4] = v(3'd5, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
      end else begin
        ev[3] = v(3'd4, 4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        ev[4] = v(3'd5, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      end
      ev[5] = ev[0];
      IR_IN = irs[k]; RUN = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
        @(negedge CLK); #1;
        total++;
        if (obs() !== ev[i]) $display("FAIL inc_dec_ldb ir%h step%0d got %h want %h", irs[k], i, obs(), ev[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_short_ops();
    logic [17:0] ev [5];
    logic [7:0]  irs [5];
    logic        zs  [5];
    logic [17:0] t4  [5];
    irs[0] = 8'h7A; zs[0] = 1'b1; t4[0] = v(3'd4, 4'd6, 4'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    irs[1] = 8'h7A; zs[1] = 1'b0; t4[1] = v(3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    irs[2] = 8'h6C; zs[2] = 1'b0; t4[2] = v(3'd4, 4'd6, 4'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    irs[3] = 8'hE0; zs[3] = 1'b1; t4[3] = v(3'd4, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    irs[4] = 8'h95; zs[4] = 1'b1; t4[4] = v(3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ev[0] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      ev[1] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      ev[2] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      ev[3] = t4[k];
      ev[4] = ev[0];
      IR_IN = irs[k]; ZERO = zs[k]; RUN = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        @(negedge CLK); #1;
        total++;
        if (obs() !== ev[i]) $display("FAIL short_op ir%h z%0d step%0d got %h want %h", irs[k], zs[k], i, obs(), ev[i]);
        else passed++;
      end
    end
    ZERO = 1'b0;
  endtask

  task automatic test_single_step();
    logic [17:0] tbl [7];
    logic [17:0] e;
    int          s;
    int          pc_cnt;
    tbl[0] = 18'h0;
    tbl[1] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tbl[2] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    tbl[3] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tbl[4] = v(3'd4, 4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tbl[5] = v(3'd5, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tbl[6] = tbl[1];
    pc_cnt = 0;
    IR_IN = 8'h05; RUN = 1'b1; STEP_MODE = 1'b1; STEP = 1'b0;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge CLK);
        STEP = (c == 0);
        #1;
        s = (c == 0) ? p : p + 1;
        e = tbl[s];
        if (c != 0) e = e & ~18'h00030;
        total++;
        if (obs() !== e) $display("FAIL step p%0d c%0d got %h want %h", p, c, obs(), e);
        else passed++;
        if (PC_EN === 1'b1 && T_STATE === 3'd2) pc_cnt++;
      end
    end
    @(negedge CLK);
    STEP = 1'b0;
    total++;
    if (pc_cnt !== 1) $display("FAIL step_pc_en_count got %0d want 1", pc_cnt);
    else passed++;
    STEP_MODE = 1'b0;
  endtask

  task automatic test_halt();
    logic [17:0] ev [5];
    logic [17:0] eh;
    logic [2:0]  bits;
    eh = v(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    ev[0] = v(3'd1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[1] = v(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    ev[2] = v(3'd3, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    ev[3] = v(3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    ev[4] = eh;
    IR_IN = 8'hF0; RUN = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      total++;
      if (obs() !== ev[i]) $display("FAIL halt_entry step%0d got %h want %h", i, obs(), ev[i]);
      else passed++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      bits = i[2:0];
      RUN = bits[0]; STEP = bits[1]; STEP_MODE = bits[2];
      #1;
      total++;
      if (obs() !== eh) $display("FAIL halt_hold cyc%0d got %h want %h", i, obs(), eh);
      else passed++;
    end
    @(negedge CLK);
    RUN = 1'b0; STEP = 1'b0; STEP_MODE = 1'b0;
    RESET = 1'b1;
    #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL halt_reset got %h want %h", obs(), 18'h0);
    else passed++;
    RESET = 1'b0;
    @(negedge CLK); #1;
    total++;
    if (obs() !== 18'h0) $display("FAIL halt_idle_after got %h want %h", obs(), 18'h0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_inc_dec_ldb();
    test_short_ops();
    test_single_step();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
- Controller/sequencer (CNTRL, select code 4'b0111) for the 8-bit bus computer.
- Steps a T-state ring: fetch (T1–T3), then a variable-length execute (T4–T7).
- Generates bus source/destination selects, output/write enables, PC increment, ALU op code and halt for PC, ACC, BREG, ALU, MAR, MEM, IR and OR.
- Supports free-run and single-step operation.

Parameters:
- ADDR_W, 4, operand width carried in IR_IN[ADDR_W-1:0].
- STEP_EN, 1, 1 = single-step support built; 0 = STEP_MODE/STEP ignored (free-run only).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- RUN  input  1  level; leaves IDLE when high.
- STEP_MODE  input  1  1 = advance only on STEP pulses.
- STEP  input  1  one-cycle debounced advance pulse.
- IR_IN  input  8  instruction register contents; opcode = [7:4].
- ZERO  input  1  accumulator-zero flag, sampled in T4 of JZ.
- BUS_SRC  output  4  module code driving bus (PC=0, ACC=1, BREG=2, ALU=3, MAR=4, MEM=5, IR=6, OR=8).
- BUS_DST  output  4  module code written from bus, same encoding.
- OE  output  1  BUS_SRC valid and driving.
- WE  output  1  BUS_DST write strobe.
- PC_EN  output  1  program counter increment.
- OP  output  3  ALU op code (ADD=000, SUB=001, DEC=010, INC=011).
- HLT  output  1  computer halted.
- T_STATE  output  3  current T-state (0 = IDLE/HALT, 1–7 = T1–T7).

Behaviour:
- States: IDLE, T1..T7, HALT. Encode in one 4-bit state register.
- Outputs are Moore-decoded from state and IR_IN[7:4]. Exception: WE and PC_EN are additionally ANDed with ADV.
- ADV = ~(STEP_EN & STEP_MODE) | STEP. State advances only on edges where ADV=1. Otherwise the state and OE/BUS_SRC/BUS_DST/OP are held, and WE=PC_EN=0.
- Reset (any time, including mid-instruction):
  - state=IDLE, T_STATE=0;
  - BUS_SRC=BUS_DST=0, OE=WE=PC_EN=HLT=0, OP=000.
- IDLE: all strobes 0. Goes to T1 on the first edge with RUN=1 and ADV=1.
- Fetch:
  - T1: SRC=PC, DST=MAR, OE, WE.
  - T2: PC_EN.
  - T3: SRC=MEM, DST=IR, OE, WE.
- Execute (decode IR_IN[7:4]; IR_IN is stable from T4 until next T3). After the last listed step, the next state is T1 and unused T-states are skipped.
  - 0x0 LDA: T4 IR->MAR; T5 MEM->ACC.
  - 0x1 ADD: T4 IR->MAR; T5 MEM->BREG; T6 no transfer (registered ALU settles); T7 ALU->ACC. OP=000 during T4–T7.
  - 0x2 SUB: as ADD with OP=001.
  - 0x3 LDB: T4 IR->MAR; T5 MEM->BREG.
  - 0x4 INC: T4 settle (OP=011); T5 ALU->ACC.
  - 0x5 DEC: T4 settle (OP=010); T5 ALU->ACC.
  - 0x6 JMP: T4 IR->PC.
  - 0x7 JZ: T4 IR->PC if ZERO=1; otherwise T4 has no strobes.
  - 0xE OUT: T4 ACC->OR.
  - 0xF HLT: T4 sets state to HALT.
  - All other opcodes: NOP, T4 with no strobes, then T1.
- Outside ALU instructions, OP=000.
- HALT: HLT=1, all other strobes 0, T_STATE=0. Left only via RESET; RUN and STEP are ignored.
- OE=1 only when a transfer is defined; BUS_SRC/BUS_DST=0 when OE/WE are 0.
- Exactly one source drives per cycle. WE never asserts without OE in the same cycle, except for PC_EN-only T2.
- RUN deassertion mid-instruction has no effect. RUN is checked only in IDLE.

Test Plan:
- RESET pulse mid-T5 of ADD -> all outputs 0 and T_STATE=0 asynchronously. With RUN=1, T1 follows on the first edge after release.
- RUN=1, IR_IN=8'h05 (LDA 5) -> T1 SRC=0/DST=4, T2 PC_EN, T3 SRC=5/DST=6, T4 SRC=6/DST=4, T5 SRC=5/DST=1, then T1. WE=1 on T1, T3, T4, T5.
- IR_IN=8'h17 (ADD 7) -> OP=000 for T4–T7, T6 has no strobes, T7 SRC=3/DST=1. Instruction length is 7 cycles.
- IR_IN=8'h7A with ZERO=1 -> T4 SRC=6/DST=0 WE=1. With ZERO=0 -> T4 has no strobes. Both cases then go to T1.
- STEP_MODE=1, STEP pulsed every 5 cycles -> T_STATE changes once per pulse. During T2, PC_EN is high only on the pulse cycle (exactly one increment).
- IR_IN=8'hF0 -> HALT after T4, HLT=1 held over 20 cycles with RUN/STEP toggling. RESET returns to IDLE with HLT=0.
